// File: rtl/hsi_tx_arb.sv
// hsi_tx_arb: arbitrates the HSI frame transmitter between the telemetry (TM)
// and service-request (SR) paths. TM wins ties. SR grants are held off while
// pre_tm is high. Each completed frame is followed by a fixed inter-frame gap.
// Failed SR frames are re-armed through sr_repeat_req until the retry budget
// runs out.
//
// Optional macro HSI_TX_TIMEOUT_EN: when defined, a BUSY phase that lasts
// TIMEOUT_TICKS cycles without tx_done is closed as if tx_done=1 and
// tx_err=1 had arrived in that cycle.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tm_tx_rdy, sr_tx_rdy        pending-frame requests (held until acked)
//   pre_tm                      blocks new SR grants while high
//   tx_done, tx_err             end-of-frame pulse and its error qualifier
//   tm_tx_ack, sr_tx_ack        one-cycle grant pulses
//   tx_start                    one-cycle transmitter start pulse
//   tx_sel                      payload select (1 = TM, 0 = SR)
//   sr_repeat_req               one-cycle SR re-arm request
//   sr_fail, tm_fail            one-cycle failure pulses
//   busy                        high whenever the FSM is not IDLE
module hsi_tx_arb #(
  parameter int unsigned GAP_TICKS     = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TIMEOUT_TICKS = 8192
) (
  input  logic clk,
  input  logic rst,
  input  logic tm_tx_rdy,
  input  logic sr_tx_rdy,
  input  logic pre_tm,
  input  logic tx_done,
  input  logic tx_err,
  output logic tm_tx_ack,
  output logic sr_tx_ack,
  output logic tx_start,
  output logic tx_sel,
  output logic sr_repeat_req,
  output logic sr_fail,
  output logic tm_fail,
  output logic busy
);

  localparam int unsigned GAP_W   = 8;
  localparam int unsigned RETRY_W = 4;

  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_TICKS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sel;
  logic               sel_nxt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_cnt_nxt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_cnt_nxt;

  logic tm_tx_ack_nxt;
  logic sr_tx_ack_nxt;
  logic tx_start_nxt;
  logic sr_repeat_req_nxt;
  logic sr_fail_nxt;
  logic tm_fail_nxt;
  logic busy_nxt;

  // Effective end-of-frame event and its error flag as seen by the FSM.
  logic done_eff;
  logic err_eff;
  logic fin;

`ifdef HSI_TX_TIMEOUT_EN
  localparam int unsigned TO_W = 16;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            to_hit;

  // Counts BUSY cycles; zero outside BUSY so every BUSY entry starts clean.
  assign to_hit     = (state == BUSY) && (to_cnt == TO_LAST);
  assign to_cnt_nxt = (state == BUSY) ? (to_cnt + TO_W'(1)) : '0;
  assign done_eff   = tx_done | to_hit;
  assign err_eff    = tx_err  | to_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt_nxt;
    end
  end
`else
  assign done_eff = tx_done;
  assign err_eff  = tx_err;
`endif

  assign fin    = (state == BUSY) && done_eff;
  assign tx_sel = sel;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= 1'b0;
      gap_cnt       <= '0;
      retry_cnt     <= '0;
      tm_tx_ack     <= 1'b0;
      sr_tx_ack     <= 1'b0;
      tx_start      <= 1'b0;
      sr_repeat_req <= 1'b0;
      sr_fail       <= 1'b0;
      tm_fail       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      sel           <= sel_nxt;
      gap_cnt       <= gap_cnt_nxt;
      retry_cnt     <= retry_cnt_nxt;
      tm_tx_ack     <= tm_tx_ack_nxt;
      sr_tx_ack     <= sr_tx_ack_nxt;
      tx_start      <= tx_start_nxt;
      sr_repeat_req <= sr_repeat_req_nxt;
      sr_fail       <= sr_fail_nxt;
      tm_fail       <= tm_fail_nxt;
      busy          <= busy_nxt;
    end
  end

  // Next-state logic; sel is only re-latched when a new grant is issued.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: begin
        if (tm_tx_rdy) begin
          sel_nxt   = 1'b1;
          state_nxt = GRANT;
        end else if (sr_tx_rdy && !pre_tm) begin
          sel_nxt   = 1'b0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt = BUSY;
      end
      BUSY: begin
        if (done_eff) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output next values: grant pulses track entry into GRANT, completion
  // pulses appear the cycle after the frame ends.
  always_comb begin
    tm_tx_ack_nxt     = 1'b0;
    sr_tx_ack_nxt     = 1'b0;
    tx_start_nxt      = 1'b0;
    sr_repeat_req_nxt = 1'b0;
    sr_fail_nxt       = 1'b0;
    tm_fail_nxt       = 1'b0;
    busy_nxt          = (state_nxt != IDLE);
    retry_cnt_nxt     = retry_cnt;

    if (state_nxt == GRANT) begin
      tx_start_nxt  = 1'b1;
      tm_tx_ack_nxt = sel_nxt;
      sr_tx_ack_nxt = ~sel_nxt;
    end

    if (fin) begin
      if (sel) begin
        // TM frames are never retried; retry_cnt belongs to SR only.
        tm_fail_nxt = err_eff;
      end else if (!err_eff) begin
        retry_cnt_nxt = '0;
      end else if (retry_cnt < RETRY_MAX) begin
        sr_repeat_req_nxt = 1'b1;
        retry_cnt_nxt     = retry_cnt + RETRY_W'(1);
      end else begin
        sr_fail_nxt   = 1'b1;
        retry_cnt_nxt = '0;
      end
    end
  end

endmodule

// File: tb/tb_hsi_tx_arb.sv
// Self-checking bench for hsi_tx_arb. Output vector order:
// {tm_tx_ack, sr_tx_ack, tx_start, tx_sel, sr_repeat_req, sr_fail, tm_fail, busy}
module tb_hsi_tx_arb;

  localparam int unsigned GAP = 16;

  localparam logic [7:0] M_ALL    = 8'b1111_1111;
  localparam logic [7:0] M_NOSEL  = 8'b1110_1111;
  localparam logic [7:0] GRANT_TM = 8'b1011_0001;
  localparam logic [7:0] GRANT_SR = 8'b0110_0001;
  localparam logic [7:0] BUSY_TM  = 8'b0001_0001;
  localparam logic [7:0] BUSY_SR  = 8'b0000_0001;
  localparam logic [7:0] GAPV     = 8'b0000_0001;
  localparam logic [7:0] IDLEV    = 8'b0000_0000;
  localparam logic [7:0] REP      = 8'b0000_1000;
  localparam logic [7:0] SRF      = 8'b0000_0100;
  localparam logic [7:0] TMF      = 8'b0000_0010;
  localparam logic [7:0] NONE     = 8'b0000_0000;

  logic clk = 1'b0;
  logic rst;
  logic tm_tx_rdy, sr_tx_rdy, pre_tm, tx_done, tx_err;
  logic tm_tx_ack, sr_tx_ack, tx_start, tx_sel;
  logic sr_repeat_req, sr_fail, tm_fail, busy;
  logic [7:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    int         n;
    logic       r, t, s, p, d, e;
    logic [7:0] exp;
    logic [7:0] mask;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  hsi_tx_arb #(
    .GAP_TICKS    (GAP),
    .MAX_RETRY    (3),
    .TIMEOUT_TICKS(100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tm_tx_rdy    (tm_tx_rdy),
    .sr_tx_rdy    (sr_tx_rdy),
    .pre_tm       (pre_tm),
    .tx_done      (tx_done),
    .tx_err       (tx_err),
    .tm_tx_ack    (tm_tx_ack),
    .sr_tx_ack    (sr_tx_ack),
    .tx_start     (tx_start),
    .tx_sel       (tx_sel),
    .sr_repeat_req(sr_repeat_req),
    .sr_fail      (sr_fail),
    .tm_fail      (tm_fail),
    .busy         (busy)
  );

  assign obs = {tm_tx_ack, sr_tx_ack, tx_start, tx_sel, sr_repeat_req, sr_fail, tm_fail, busy};

  // Drive inputs for one cycle, then sample outputs on the falling edge.
  task automatic step(input logic r, t, s, p, d, e);
    rst       = r;
    tm_tx_rdy = t;
    sr_tx_rdy = s;
    pre_tm    = p;
    tx_done   = d;
    tx_err    = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input int idx, input logic [7:0] exp, input logic [7:0] mask);
    n_cmp++;
    if ((obs & mask) !== (exp & mask)) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b expected %b (mask %b)", nm, idx, obs, exp, mask);
    end
  endtask

  function automatic void add(input string nm, input int n, input logic r, t, s, p, d, e,
                              input logic [7:0] exp, input logic [7:0] mask);
    vec_t v;
    v.name = nm; v.n = n;
    v.r = r; v.t = t; v.s = s; v.p = p; v.d = d; v.e = e;
    v.exp = exp; v.mask = mask;
    vq.push_back(v);
  endfunction

  // Busy/done/gap/idle rows of a frame. Stray tx_err in BUSY and stray
  // tx_done/tx_err in GAP must have no effect.
  function automatic void add_tail(input string nm, input bit is_tm, input int busy_n,
                                   input logic err, input logic [7:0] pulse);
    add({nm, "_busy"}, busy_n, 0, 0, 0, 0, 0, 1, is_tm ? BUSY_TM : BUSY_SR, M_ALL);
    add({nm, "_done"}, 1,      0, 0, 0, 0, 1, err, GAPV | pulse, M_NOSEL);
    add({nm, "_gap"},  GAP-1,  0, 0, 0, 0, 1, 1, GAPV, M_NOSEL);
    add({nm, "_idle"}, 1,      0, 0, 0, 0, 0, 0, IDLEV, M_NOSEL);
  endfunction

  function automatic void add_frame(input string nm, input bit is_tm, input int busy_n,
                                    input logic err, input logic [7:0] pulse);
    add({nm, "_grant"}, 1, 0, is_tm, !is_tm, 0, 0, 0, is_tm ? GRANT_TM : GRANT_SR, M_ALL);
    add_tail(nm, is_tm, busy_n, err, pulse);
  endfunction

  task automatic run_rows();
    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].n; k++) begin
        step(vq[i].r, vq[i].t, vq[i].s, vq[i].p, vq[i].d, vq[i].e);
        check(vq[i].name, k, vq[i].exp, vq[i].mask);
      end
    end
    vq.delete();
  endtask

  initial begin
    rst = 1'b1; tm_tx_rdy = 1'b0; sr_tx_rdy = 1'b0;
    pre_tm = 1'b0; tx_done = 1'b0; tx_err = 1'b0;
    @(negedge clk);

    // Reset and TM-only frame: grant 1 cycle after rdy, 16-cycle gap.
    add("reset", 2, 1, 0, 0, 0, 0, 0, IDLEV, M_ALL);
    add("idle",  8, 0, 0, 0, 0, 0, 0, IDLEV, M_ALL);
    add_frame("tm_ok", 1, 29, 0, NONE);
    add("idle_stray", 3, 0, 0, 0, 0, 1, 1, IDLEV, M_NOSEL);

    // Simultaneous requests: TM first, SR held and granted right after GAP.
    add("sim_grant_tm", 1, 0, 1, 1, 0, 0, 0, GRANT_TM, M_ALL);
    add("sim_busy",     4, 0, 0, 1, 0, 0, 0, BUSY_TM, M_ALL);
    add("sim_done",     1, 0, 0, 1, 0, 1, 0, GAPV, M_NOSEL);
    add("sim_gap",  GAP-1, 0, 0, 1, 0, 0, 0, GAPV, M_NOSEL);
    add("sim_idle",     1, 0, 0, 1, 0, 0, 0, IDLEV, M_NOSEL);
    add("sim_grant_sr", 1, 0, 0, 1, 0, 0, 0, GRANT_SR, M_ALL);
    add_tail("sim_sr", 0, 3, 0, NONE);

    // pre_tm blocks SR for 500 cycles; grant follows release by one cycle.
    add("pre_block",  500, 0, 0, 1, 1, 0, 0, IDLEV, M_NOSEL);
    add("pre_release",  1, 0, 0, 1, 0, 0, 0, GRANT_SR, M_ALL);
    add_tail("pre_sr", 0, 2, 0, NONE);
    add("pre_tm_grant", 1, 0, 1, 0, 1, 0, 0, GRANT_TM, M_ALL);
    add_tail("pre_tm", 1, 2, 0, NONE);

    // SR retry exhaustion, then a clean success.
    add_frame("ex_e1", 0, 3, 1, REP);
    add_frame("ex_e2", 0, 3, 1, REP);
    add_frame("ex_e3", 0, 3, 1, REP);
    add_frame("ex_e4", 0, 3, 1, SRF);
    add_frame("ex_ok", 0, 3, 0, NONE);

    // TM error between SR retries keeps retry_cnt.
    add_frame("tmx_sr1", 0, 2, 1, REP);
    add_frame("tmx_tm",  1, 2, 1, TMF);
    add_frame("tmx_sr2", 0, 2, 1, REP);
    add_frame("tmx_sr3", 0, 2, 1, REP);
    add_frame("tmx_sr4", 0, 2, 1, SRF);

    // A successful SR frame clears a partial retry count.
    add_frame("clr_e1", 0, 2, 1, REP);
    add_frame("clr_ok", 0, 2, 0, NONE);
    add_frame("clr_e2", 0, 2, 1, REP);
    add_frame("clr_e3", 0, 2, 1, REP);
    add_frame("clr_e4", 0, 2, 1, REP);
    add_frame("clr_e5", 0, 2, 1, SRF);
    run_rows();

    // Reset mid-BUSY: silent abandon, retry_cnt cleared.
    add_frame("prerst_sr", 0, 2, 1, REP);
    run_rows();
    step(0, 1, 0, 0, 0, 0); check("rst_grant", 0, GRANT_TM, M_ALL);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0); check("rst_busy", k, BUSY_TM, M_ALL);
    end
    step(1, 0, 0, 0, 0, 0); check("rst_mid_busy", 0, IDLEV, M_ALL);
    step(0, 0, 0, 0, 1, 1); check("rst_no_pulse", 0, IDLEV, M_ALL);
    step(0, 0, 0, 0, 0, 0); check("rst_idle", 0, IDLEV, M_ALL);
    add_frame("post_e1", 0, 2, 1, REP);
    add_frame("post_e2", 0, 2, 1, REP);
    add_frame("post_e3", 0, 2, 1, REP);
    add_frame("post_e4", 0, 2, 1, SRF);
    run_rows();

`ifdef HSI_TX_TIMEOUT_EN
    // Timeout after 100 BUSY cycles acts as an errored completion.
    add("to_sr_grant", 1, 0, 0, 1, 0, 0, 0, GRANT_SR, M_ALL);
    add("to_sr_busy", 100, 0, 0, 0, 0, 0, 0, BUSY_SR, M_ALL);
    add("to_sr_hit",    1, 0, 0, 0, 0, 0, 0, GAPV | REP, M_NOSEL);
    add("to_sr_gap", GAP-1, 0, 0, 0, 0, 0, 0, GAPV, M_NOSEL);
    add("to_sr_idle",   1, 0, 0, 0, 0, 0, 0, IDLEV, M_NOSEL);
    add("to_tm_grant",  1, 0, 1, 0, 0, 0, 0, GRANT_TM, M_ALL);
    add("to_tm_busy", 100, 0, 0, 0, 0, 0, 0, BUSY_TM, M_ALL);
    add("to_tm_hit",    1, 0, 0, 0, 0, 0, 0, GAPV | TMF, M_NOSEL);
    add("to_tm_gap", GAP-1, 0, 0, 0, 0, 0, 0, GAPV, M_NOSEL);
    add("to_tm_idle",   1, 0, 0, 0, 0, 0, 0, IDLEV, M_NOSEL);
    run_rows();
`else
    // Without the timeout, BUSY waits indefinitely for tx_done.
    add_frame("long_busy", 0, 150, 0, NONE);
    run_rows();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
